// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the registered 3-to-8 decoder.
// Default widths live here so the core, interface and top agree.
package decoder_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 1 << DEC_IN_W;

  function automatic logic [DEC_OUT_W-1:0] onehot(input logic [DEC_IN_W-1:0] sel);
    onehot = DEC_OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_if.sv
// Select/enable inputs and decoded outputs of the decoder, bundled as one port.
// The master drives en/D; the slave (the decoder) drives Y/valid.
interface decoder_if
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W
);

  logic                   en;
  logic [IN_W-1:0]        D;
  logic [(1<<IN_W)-1:0]   Y;
  logic                   valid;

  modport master (output en, output D, input Y, input valid);
  modport slave  (input en, input D, output Y, output valid);

endinterface

// File: rtl/decoder_core.sv
// Purely combinational binary-to-one-hot core; bit i is set iff d_i == i.
// No clock, so it can be dropped into unregistered contexts as-is.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int IN_W = DEC_IN_W
) (
  input  logic [IN_W-1:0]      d_i,
  output logic [(1<<IN_W)-1:0] onehot_o
);

  localparam int OUT_W = 1 << IN_W;

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_bit
    assign onehot_o[gi] = (d_i == IN_W'(gi));
  end

endmodule

// File: rtl/decoder_3x8.sv
// Registered one-hot (or one-cold) decoder with enable gating and a valid flag.
// Y and valid are the only state; both clear asynchronously to the idle pattern.
module decoder_3x8
  import decoder_pkg::*;
#(
  parameter int IN_W       = DEC_IN_W,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  decoder_if.slave  bus
);

  localparam int OUT_W = 1 << IN_W;
  // XOR mask doubles as the idle pattern: all zeros active-high, all ones active-low.
  localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

  if (IN_W < 1 || IN_W > 6) begin : g_bad_width
    $fatal(1, "decoder_3x8: IN_W must be in 1..6");
  end

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;
  logic             valid_d;
  logic             valid_q;

  decoder_core #(.IN_W(IN_W)) u_core (
    .d_i      (bus.D),
    .onehot_o (onehot)
  );

  always_comb begin
    y_d     = POL_MASK;
    valid_d = 1'b0;
    if (bus.en) begin
      y_d     = onehot ^ POL_MASK;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= POL_MASK;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder_3x8.sv
// Bench for decoder_3x8: active-high and active-low builds share one stimulus stream,
// a per-cycle index model is compared on every falling edge, plus literal spot checks.
module tb_decoder_3x8;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decoder_if #(.IN_W(3)) bus ();
  decoder_if #(.IN_W(3)) bus_al ();

  assign bus_al.en = bus.en;
  assign bus_al.D  = bus.D;

  decoder_3x8 #(.IN_W(3), .ACTIVE_LOW(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  decoder_3x8 #(.IN_W(3), .ACTIVE_LOW(1'b1)) dut_al (
    .clk (clk),
    .rst (rst),
    .bus (bus_al.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index of the line that should be active, -1 when nothing is decoded.
  int exp_idx = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) exp_idx <= -1;
    else     exp_idx <= bus.en ? int'(bus.D) : -1;
  end

  always @(negedge clk) begin
    logic [7:0] exp_y;
    logic       exp_v;
    exp_y = (exp_idx < 0) ? 8'd0 : 8'(1 << exp_idx);
    exp_v = (exp_idx >= 0);
    chk("model_Y",         bus.Y, exp_y);
    chk("model_valid",     {7'd0, bus.valid}, {7'd0, exp_v});
    chk("model_Y_al",      bus_al.Y, ~exp_y);
    chk("model_valid_al",  {7'd0, bus_al.valid}, {7'd0, exp_v});
    chk("popcount_Y",      8'($countones(bus.Y)), {7'd0, bus.valid});
    chk("popcount_Y_al",   8'($countones(~bus_al.Y)), {7'd0, bus_al.valid});
  end

  // One cycle per call: drive after the falling edge, return just after the next rising edge.
  task automatic apply(input logic e, input logic [2:0] d);
    @(negedge clk);
    bus.en = e;
    bus.D  = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  initial begin
    rst    = 1'b0;
    bus.en = 1'b1;
    bus.D  = 3'd5;
    #1 rst = 1'b1;
    #2;
    chk("por_Y", bus.Y, 8'h00);
    chk("por_Y_al", bus_al.Y, 8'hFF);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Asynchronous reset mid-cycle with en=1, D=101
    apply(1'b1, 3'd5);
    chk("pre_rst_Y", bus.Y, 8'h20);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_Y", bus.Y, 8'h00);
    chk("async_rst_valid", {7'd0, bus.valid}, 8'h00);
    chk("async_rst_Y_al", bus_al.Y, 8'hFF);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_hold_Y", bus.Y, 8'h00);
      chk("rst_hold_valid", {7'd0, bus.valid}, 8'h00);
    end
    rst = 1'b0;

    // Exhaustive sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 3'(i));
      chk("sweep_Y", bus.Y, sweep_exp[i]);
      chk("sweep_valid", {7'd0, bus.valid}, 8'h01);
    end

    // Enable gating
    apply(1'b0, 3'd3);
    chk("gate_off_Y", bus.Y, 8'h00);
    chk("gate_off_valid", {7'd0, bus.valid}, 8'h00);
    apply(1'b1, 3'd3);
    chk("gate_on_Y", bus.Y, 8'h08);

    // Active-low build
    apply(1'b1, 3'd2);
    chk("al_dec_Y", bus_al.Y, 8'hFB);
    apply(1'b0, 3'd2);
    chk("al_idle_Y", bus_al.Y, 8'hFF);

    // Random back-to-back traffic, mostly enabled
    for (int i = 0; i < 1000; i++) begin
      apply($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)));
    end

    // Reset mid-stream during a sweep at D=100, half-cycle pulse
    apply(1'b1, 3'd4);
    chk("mid_pre_Y", bus.Y, 8'h10);
    #2 rst = 1'b1;
    bus.D = 3'd6;
    #1;
    chk("mid_rst_Y", bus.Y, 8'h00);
    chk("mid_rst_Y_al", bus_al.Y, 8'hFF);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_post_Y", bus.Y, 8'h40);
    chk("mid_post_valid", {7'd0, bus.valid}, 8'h01);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
